// File: rtl/tconv_pkg.sv
// Shared types and helpers for the transposed-convolution engine:
// FSM states, output/accumulator sizing and signed saturation.
package tconv_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_K  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  function automatic int out_dim(input int n, input int k, input int s);
    return (n - 1) * s + k;
  endfunction

  function automatic int accum_width(input int pw, input int cin,
                                     input int k);
    return 2 * pw + $clog2(cin * k * k);
  endfunction

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 pw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (pw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (pw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tconv_acc_grid.sv
// Accumulator array for tconv2d_engine: clears on job start and
// scatter-adds one registered pixel times the KxK kernel per cycle.
module tconv_acc_grid
  import tconv_pkg::*;
#(
  parameter int N      = 2,
  parameter int K      = 3,
  parameter int CIN    = 1,
  parameter int PW     = 8,
  parameter int STRIDE = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_clr,
  input  logic                               i_add,
  input  logic signed [PW-1:0]               i_pix,
  input  logic [cw(CIN)-1:0]                 i_ch,
  input  logic [cw(N)-1:0]                   i_row,
  input  logic [cw(N)-1:0]                   i_col,
  input  logic [CIN*K*K*PW-1:0]              i_wts,
  input  logic [cw(out_dim(N,K,STRIDE)**2)-1:0] i_rd_idx,
  output logic signed [accum_width(PW,CIN,K)-1:0] o_rd_data
);

  localparam int OD  = out_dim(N, K, STRIDE);
  localparam int NO  = OD * OD;
  localparam int AW  = accum_width(PW, CIN, K);
  localparam int OIW = cw(NO);

  logic signed [AW-1:0]   r_acc  [NO];
  logic signed [2*PW-1:0] w_prod [K*K];

  function automatic logic [OIW-1:0] pos(input int r, input int c);
    return OIW'(r * OD + c);
  endfunction

  always_comb begin
    for (int t = 0; t < K * K; t++)
      w_prod[t] = i_pix *
        $signed(i_wts[(int'(i_ch) * K * K + t) * PW +: PW]);
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int p = 0; p < NO; p++)
        r_acc[p] <= '0;
    end else if (i_add) begin
      // A single pixel never hits the same cell twice, so NBA is safe.
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          r_acc[pos(int'(i_row) * STRIDE + i, int'(i_col) * STRIDE + j)] <=
            r_acc[pos(int'(i_row) * STRIDE + i,
                      int'(i_col) * STRIDE + j)] + AW'(w_prod[i*K+j]);
    end
  end

  assign o_rd_data = r_acc[i_rd_idx];

endmodule

// File: rtl/tconv2d_engine.sv
// Streaming transposed-convolution engine: FSM, counters, handshakes.
// Define TCONV_RELU_EN to clamp negative results to 0 before saturation.
module tconv2d_engine
  import tconv_pkg::*;
#(
  parameter int N           = 2,
  parameter int K           = 3,
  parameter int CIN         = 1,
  parameter int PIXEL_WIDTH = 8,
  parameter int STRIDE      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   keep_kernel,
  input  logic                   kern_valid,
  output logic                   kern_ready,
  input  logic [PIXEL_WIDTH-1:0] kern_data,
  input  logic                   img_valid,
  output logic                   img_ready,
  input  logic [PIXEL_WIDTH-1:0] img_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int PW  = PIXEL_WIDTH;
  localparam int OD  = out_dim(N, K, STRIDE);
  localparam int NO  = OD * OD;
  localparam int AW  = accum_width(PW, CIN, K);
  localparam int NW  = CIN * K * K;
  localparam int KCW = cw(NW);
  localparam int CHW = cw(CIN);
  localparam int RCW = cw(N);
  localparam int OIW = cw(NO);

  state_t r_state, w_next;
  logic w_clr, w_kacc, w_iacc, w_oacc;
  logic w_klast, w_plast, w_olast;
  logic r_kstored, r_done, r_px_v;
  logic [KCW-1:0] r_kcnt;
  logic [CHW-1:0] r_c, r_pc;
  logic [RCW-1:0] r_r, r_q, r_pr, r_pq;
  logic signed [PW-1:0] r_px;
  logic [NW*PW-1:0] r_wts;
  logic [OIW-1:0] r_ocnt;
  logic signed [AW-1:0] w_acc_rd, w_rect;
  logic [PW-1:0] w_sat;

  assign w_klast = (r_kcnt == KCW'(NW - 1));
  assign w_plast = (r_c == CHW'(CIN - 1)) && (r_r == RCW'(N - 1)) &&
                   (r_q == RCW'(N - 1));
  assign w_olast = (r_ocnt == OIW'(NO - 1));

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    kern_ready = 1'b0;
    img_ready  = 1'b0;
    out_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_clr  = 1'b1;
        w_next = (keep_kernel && r_kstored) ? S_COMPUTE : S_LOAD_K;
      end
      S_LOAD_K: begin
        kern_ready = 1'b1;
        if (kern_valid && w_klast) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        img_ready = 1'b1;
        if (img_valid && w_plast) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Hold off one cycle while the last pixel is still accumulating.
        out_valid = !r_px_v;
        if (out_valid && out_ready && w_olast) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_kacc = kern_valid && kern_ready;
  assign w_iacc = img_valid && img_ready;
  assign w_oacc = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_kstored <= 1'b0;
      r_done    <= 1'b0;
      r_px_v    <= 1'b0;
      r_px      <= '0;
      r_pc      <= '0;
      r_pr      <= '0;
      r_pq      <= '0;
      r_kcnt    <= '0;
      r_c       <= '0;
      r_r       <= '0;
      r_q       <= '0;
      r_ocnt    <= '0;
      r_wts     <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_oacc && w_olast;
      r_px_v  <= w_iacc;
      r_px    <= img_data;
      r_pc    <= r_c;
      r_pr    <= r_r;
      r_pq    <= r_q;
      if (w_clr) begin
        r_kcnt <= '0;
        r_c    <= '0;
        r_r    <= '0;
        r_q    <= '0;
        r_ocnt <= '0;
      end
      if (w_kacc) begin
        r_wts[r_kcnt*PW +: PW] <= kern_data;
        r_kcnt <= r_kcnt + 1'b1;
        if (w_klast) r_kstored <= 1'b1;
      end
      if (w_iacc) begin
        if (r_q == RCW'(N - 1)) begin
          r_q <= '0;
          if (r_r == RCW'(N - 1)) begin
            r_r <= '0;
            r_c <= r_c + 1'b1;
          end else begin
            r_r <= r_r + 1'b1;
          end
        end else begin
          r_q <= r_q + 1'b1;
        end
      end
      if (w_oacc) r_ocnt <= r_ocnt + 1'b1;
    end
  end

  tconv_acc_grid #(
    .N(N), .K(K), .CIN(CIN), .PW(PW), .STRIDE(STRIDE)
  ) u_grid (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_add    (r_px_v),
    .i_pix    (r_px),
    .i_ch     (r_pc),
    .i_row    (r_pr),
    .i_col    (r_pq),
    .i_wts    (r_wts),
    .i_rd_idx (r_ocnt),
    .o_rd_data(w_acc_rd)
  );

`ifdef TCONV_RELU_EN
  assign w_rect = w_acc_rd[AW-1] ? '0 : w_acc_rd;
`else
  assign w_rect = w_acc_rd;
`endif

  assign w_sat    = PW'(saturate(64'(w_rect), PW));
  assign out_data = out_valid ? w_sat : '0;
  assign out_last = out_valid && w_olast;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_tconv2d_engine.sv
// Directed scoreboard bench for tconv2d_engine (CIN=1 and CIN=2 builds).
module tb_tconv2d_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1, keep_kernel;
  logic kern_valid, img_valid, out_ready;
  logic [7:0] kern_data, img_data;
  logic [1:0] kr, ir, ov, ol, bz, dn;
  logic signed [7:0] od0, od1;

  typedef struct {int d; bit l;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int gw[18];
  int gx[8];
  int kr_cnt[2];
  int done_cnt[2];

  tconv2d_engine u_dut (
    .clk(clk), .rst(rst), .start(start0), .keep_kernel(keep_kernel),
    .kern_valid(kern_valid), .kern_ready(kr[0]), .kern_data(kern_data),
    .img_valid(img_valid), .img_ready(ir[0]), .img_data(img_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
    .out_last(ol[0]), .busy(bz[0]), .done(dn[0])
  );

  tconv2d_engine #(.CIN(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start1), .keep_kernel(keep_kernel),
    .kern_valid(kern_valid), .kern_ready(kr[1]), .kern_data(kern_data),
    .img_valid(img_valid), .img_ready(ir[1]), .img_data(img_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
    .out_last(ol[1]), .busy(bz[1]), .done(dn[1])
  );

  initial begin
    kr_cnt[0] = 0; kr_cnt[1] = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
  end

  always @(negedge clk) begin
    if (kr[0] === 1'b1) kr_cnt[0]++;
    if (kr[1] === 1'b1) kr_cnt[1]++;
    if (dn[0] === 1'b1) done_cnt[0]++;
    if (dn[1] === 1'b1) done_cnt[1]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int odsel(input int s);
    return s ? int'(od1) : int'(od0);
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: 5x5 output, stride 2, 3x3 kernel, summed over channels.
  task automatic push_model(input int cin);
    int acc[25];
    int v;
    for (int p = 0; p < 25; p++) acc[p] = 0;
    for (int c = 0; c < cin; c++)
      for (int r = 0; r < 2; r++)
        for (int q = 0; q < 2; q++)
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc[(r*2+i)*5 + q*2+j] += gx[c*4+r*2+q] * gw[c*9+i*3+j];
    for (int p = 0; p < 25; p++) begin
      v = acc[p];
`ifdef TCONV_RELU_EN
      if (v < 0) v = 0;
`endif
      sb.push_back('{sat8(v), p == 24});
    end
  endtask

  task automatic send_k(input int s, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      kern_data = 8'(gw[k]);
      kern_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (kr[s] !== 1'b1 && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) chk("kern_ready_timeout", t, 0);
      @(posedge clk); #1;
    end
    kern_valid = 1'b0;
  endtask

  task automatic send_x(input int s, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      img_data = 8'(gx[k]);
      img_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (ir[s] !== 1'b1 && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) chk("img_ready_timeout", t, 0);
      @(posedge clk); #1;
    end
    img_valid = 1'b0;
  endtask

  task automatic drain(input int s, input int stall);
    int idx, t, hold;
    exp_t e;
    idx = 0; t = 0;
    out_ready = 1'b1;
    while (idx < 25 && t < 300) begin
      @(negedge clk); t++;
      if (ov[s] === 1'b1) begin
        if (idx == 0) chk("first_out_latency", t, 2);
        if (idx == stall) begin
          out_ready = 1'b0;
          hold = odsel(s);
          repeat (3) begin
            @(posedge clk); @(negedge clk); t++;
            chk("stall_valid", int'(ov[s]), 1);
            chk("stall_hold", odsel(s), hold);
          end
          out_ready = 1'b1;
        end
        e = sb.pop_front();
        chk("out_data", odsel(s), e.d);
        chk("out_last", int'(ol[s]), int'(e.l));
        idx++;
      end
    end
    if (idx < 25) begin
      chk("drain_timeout", idx, 25);
      sb.delete();
    end
    @(negedge clk);
    chk("done_pulse", int'(dn[s]), 1);
    chk("busy_after", int'(bz[s]), 0);
    @(negedge clk);
    chk("done_single", int'(dn[s]), 0);
  endtask

  task automatic run_job(input int s, input bit keep, input int stall,
                         input int exp_kr);
    int base;
    base = kr_cnt[s];
    push_model(s + 1);
    keep_kernel = keep;
    if (s != 0) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; keep_kernel = 1'b0;
    if (exp_kr > 0) send_k(s, 9 * (s + 1));
    send_x(s, 4 * (s + 1));
    drain(s, stall);
    chk("kern_ready_cycles", kr_cnt[s] - base, exp_kr);
  endtask

  initial begin
    int base;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; keep_kernel = 1'b0;
    kern_valid = 1'b0; img_valid = 1'b0; out_ready = 1'b0;
    kern_data = '0; img_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_kern_ready", int'(kr[0]), 0);
    chk("rst_img_ready", int'(ir[0]), 0);
    chk("rst_out_data", int'(od0), 0);
    chk("rst_out_last", int'(ol[0]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All-ones kernel, pixels 1..4, back-pressure at index 7.
    for (int k = 0; k < 9; k++) gw[k] = 1;
    for (int k = 0; k < 4; k++) gx[k] = k + 1;
    run_job(0, 1'b0, 7, 9);
    run_job(0, 1'b1, -1, 0);

    // Saturation corners.
    for (int k = 0; k < 9; k++) gw[k] = 0;
    gw[0] = 127;
    gx[0] = 127; gx[1] = 0; gx[2] = 0; gx[3] = 0;
    run_job(0, 1'b0, -1, 9);
    gx[0] = -128;
    run_job(0, 1'b1, -1, 0);

    // Mixed-sign kernel.
    for (int k = 0; k < 9; k++) gw[k] = (k % 2) ? -3 : 2;
    for (int k = 0; k < 4; k++) gx[k] = k + 1;
    run_job(0, 1'b0, -1, 9);

    // Random kernel and pixels.
    for (int k = 0; k < 9; k++) gw[k] = int'($urandom_range(255)) - 128;
    for (int k = 0; k < 4; k++) gx[k] = int'($urandom_range(255)) - 128;
    run_job(0, 1'b0, 12, 9);

    // Reset mid-COMPUTE after two pixels.
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    send_k(0, 9);
    send_x(0, 2);
    base = done_cnt[0];
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_img_ready", int'(ir[0]), 0);
    chk("abort_out_valid", int'(ov[0]), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt[0] - base, 0);
    @(posedge clk); #1;
    // keep_kernel is requested but the reset dropped the stored kernel.
    run_job(0, 1'b1, -1, 9);

    // CIN=2 build with two identical channels.
    base = kr_cnt[0];
    for (int k = 0; k < 18; k++) gw[k] = 1;
    for (int k = 0; k < 8; k++) gx[k] = (k % 4) + 1;
    run_job(1, 1'b0, -1, 18);
    chk("idle_dut_kern_ready", kr_cnt[0] - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
